// File: rtl/seg_disp_pkg.sv
// Shared definitions for the multiplexed 7-segment scan driver:
// scan FSM states, the active-low hex font and the all-segments-off pattern.
package seg_disp_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    LATCH = 2'd1,
    SHOW  = 2'd2,
    GHOST = 2'd3
  } seg_state_e;

  // All segments (and the decimal point) dark; segments are active-low.
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Active-low font, bit order g..a (bit 6 = g, bit 0 = a).
  localparam logic [6:0] HEX_FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,  // 0 1 2 3
    7'h19, 7'h12, 7'h02, 7'h78,  // 4 5 6 7
    7'h00, 7'h10, 7'h08, 7'h03,  // 8 9 A b
    7'h46, 7'h21, 7'h06, 7'h0E   // C d E F
  };

endpackage

// File: rtl/seg_hex_font.sv
// Combinational hex digit + decimal point to active-low segment pattern.
// Output bit 7 is the decimal point, bits 6:0 are segments g..a.
module seg_hex_font
  import seg_disp_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       dp,
  output logic [7:0] pattern
);

  // Decimal point is active-low like the segments.
  assign pattern = {~dp, HEX_FONT[nib]};

endmodule

// File: rtl/seg_scan_display.sv
// Parametrised multiplexed 7-segment scan driver.
// Each digit slot runs FETCH (address out) -> LATCH (capture data one cycle
// later) -> SHOW (SCAN_DIV cycles lit) -> GHOST (BLANK_CYC cycles all dark,
// skipped when BLANK_CYC = 0). Anodes and segments are active-low.
// Optional macro SEG_DIM_EN adds a 4-bit brightness input that PWM-dims the
// lit digit with a free-running 16-step counter.
// state_dbg exposes the scan FSM state for observation.
module seg_scan_display
  import seg_disp_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int ADDR_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  parameter int SCAN_DIV   = 16384,
  parameter int BLANK_CYC  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_W-1:0]     digit_addr,
  input  logic [7:0]            digit_data,
  input  logic                  raw_mode,
  input  logic [NUM_DIGITS-1:0] blank_mask,
`ifdef SEG_DIM_EN
  input  logic [3:0]            brightness,
`endif
  output logic [NUM_DIGITS-1:0] anode,
  output logic [7:0]            seg,
  output logic                  frame_start,
  output seg_state_e            state_dbg
);

  // One counter serves both the SHOW dwell and the GHOST blanking.
  localparam int CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]  SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  GHOST_LAST = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  localparam logic [ADDR_W-1:0] IDX_LAST   = ADDR_W'(NUM_DIGITS - 1);

  seg_state_e            state, state_next;
  logic [ADDR_W-1:0]     idx, idx_next, idx_adv;
  logic [CNT_W-1:0]      cnt, cnt_next;
  logic [NUM_DIGITS-1:0] digit_sel;
  logic [NUM_DIGITS-1:0] anode_next;
  logic [7:0]            seg_next;
  logic [7:0]            font_pat;
  logic                  frame_start_next;
  logic                  dim_on;

  // Wrap explicitly so non-power-of-2 digit counts never reach unused codes.
  assign idx_adv    = (idx == IDX_LAST) ? '0 : idx + 1'b1;
  assign digit_addr = idx;
  assign state_dbg  = state;

  seg_hex_font u_font (
    .nib     (digit_data[3:0]),
    .dp      (digit_data[4]),
    .pattern (font_pat)
  );

`ifdef SEG_DIM_EN
  logic [3:0] pwm_cnt;

  // Free-running PWM phase; 32 consecutive SHOW cycles see every phase twice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_cnt <= '0;
    else        pwm_cnt <= pwm_cnt + 4'd1;
  end

  assign dim_on = (pwm_cnt < brightness);
`else
  assign dim_on = 1'b1;
`endif

  // One-hot select of the current digit (1 = selected).
  always_comb begin
    digit_sel = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digit_sel[i] = (idx == ADDR_W'(i));
    end
  end

  // Next-state, digit index and dwell/blank counter.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    cnt_next   = cnt;
    unique case (state)
      FETCH: state_next = LATCH;
      LATCH: begin
        state_next = SHOW;
        cnt_next   = '0;
      end
      SHOW: begin
        if (cnt == SHOW_LAST) begin
          cnt_next = '0;
          if (BLANK_CYC == 0) begin
            state_next = FETCH;
            idx_next   = idx_adv;
          end else begin
            state_next = GHOST;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      GHOST: begin
        if (cnt == GHOST_LAST) begin
          state_next = FETCH;
          idx_next   = idx_adv;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: state_next = FETCH;
    endcase
  end

  // Registered-output values: anode lit only for cycles spent in SHOW,
  // blank_mask and dimming sampled the cycle before they take effect.
  always_comb begin
    anode_next = '1;
    if (state_next == SHOW && !(|(digit_sel & blank_mask)) && dim_on) begin
      anode_next = ~digit_sel;
    end
    seg_next = seg;
    if (state == LATCH) begin
      seg_next = raw_mode ? digit_data : font_pat;
    end else if (state_next == GHOST) begin
      seg_next = SEG_OFF;
    end
    // Registered, so the pulse accompanies the LATCH cycle of digit 0.
    frame_start_next = (state == FETCH) && (idx == '0);
  end

  // Scan FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      cnt   <= cnt_next;
    end
  end

  // Output registers; reset darkens the display immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anode       <= '1;
      seg         <= SEG_OFF;
      frame_start <= 1'b0;
    end else begin
      anode       <= anode_next;
      seg         <= seg_next;
      frame_start <= frame_start_next;
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Testbench for seg_scan_display.
// dut0: 4 digits, SCAN_DIV 4 (32 with SEG_DIM_EN), BLANK_CYC 2.
// dut1: 5 digits, SCAN_DIV 4, BLANK_CYC 0.
// Expected lit-digit episodes {gap, len, seg, anode} and frame_start intervals
// are queued by the stimulus; monitors pop and compare as episodes end.
module tb_seg_scan_display;
  import seg_disp_pkg::*;

  localparam int ND0 = 4;
`ifdef SEG_DIM_EN
  localparam int SD0 = 32;
`else
  localparam int SD0 = 4;
`endif
  localparam int BC0 = 2;
  localparam int ND1 = 5;
  localparam int SD1 = 4;
  localparam int BC1 = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0_n, rst1_n;
  logic raw0, raw1;
  logic [3:0] mask0;
  logic [4:0] mask1;
  logic [1:0] addr0;
  logic [2:0] addr1;
  logic [7:0] data0, data1;
  logic [3:0] anode0;
  logic [4:0] anode1;
  logic [7:0] seg0, seg1;
  logic fs0, fs1;
  seg_state_e dbg0, dbg1;
  logic [7:0] mem0 [4];
  logic [7:0] mem1 [5];
`ifdef SEG_DIM_EN
  logic [3:0] bright0, bright1;
`endif

  // Register-file model with one cycle of read latency.
  always @(posedge clk) begin
    data0 <= mem0[addr0];
    data1 <= (addr1 < 3'd5) ? mem1[addr1] : 8'hEE;
  end

  seg_scan_display #(.NUM_DIGITS(ND0), .SCAN_DIV(SD0), .BLANK_CYC(BC0)) dut0 (
    .clk(clk), .rst_n(rst0_n), .digit_addr(addr0), .digit_data(data0),
    .raw_mode(raw0), .blank_mask(mask0),
`ifdef SEG_DIM_EN
    .brightness(bright0),
`endif
    .anode(anode0), .seg(seg0), .frame_start(fs0), .state_dbg(dbg0)
  );

  seg_scan_display #(.NUM_DIGITS(ND1), .SCAN_DIV(SD1), .BLANK_CYC(BC1)) dut1 (
    .clk(clk), .rst_n(rst1_n), .digit_addr(addr1), .digit_data(data1),
    .raw_mode(raw1), .blank_mask(mask1),
`ifdef SEG_DIM_EN
    .brightness(bright1),
`endif
    .anode(anode1), .seg(seg1), .frame_start(fs1), .state_dbg(dbg1)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [39:0] exp0_q [$];
  logic [39:0] exp1_q [$];
  int fs0_q [$];
  int fs1_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push0(input logic [3:0] an, input logic [7:0] sg, input int gap);
    exp0_q.push_back({8'(gap), 8'(SD0), sg, 12'h000, an});
  endtask

  task automatic push1(input logic [4:0] an, input logic [7:0] sg, input int gap);
    exp1_q.push_back({8'(gap), 8'(SD1), sg, 11'h000, an});
  endtask

  // ---------------- monitors ----------------
  int cyc0, last0, fsl0, len0, gap0;
  logic on0 = 1'b0;
  logic [3:0] an0;
  logic [7:0] sg0;
  int cyc1, last1, fsl1, len1, gap1;
  logic on1 = 1'b0;
  logic [4:0] an1;
  logic [7:0] sg1;

`ifndef SEG_DIM_EN
  // dut0: a lit episode is a run of identical non-all-ones anode samples.
  always @(negedge clk) begin : mon0
    logic [39:0] e;
    if (!rst0_n) begin
      cyc0 = 0; last0 = 0; fsl0 = 0; on0 = 1'b0;
    end else begin
      cyc0++;
      if (fs0) begin
        if (fs0_q.size() > 0) check("dut0 frame_start interval", 64'(cyc0 - fsl0), 64'(fs0_q.pop_front()));
        fsl0 = cyc0;
      end
      if (on0 && anode0 == an0) begin
        len0++;
      end else if (on0) begin
        on0 = 1'b0;
        if (exp0_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL dut0 unexpected lit digit: anode %b seg %h, none expected", an0, sg0);
        end else begin
          e = exp0_q.pop_front();
          check("dut0 anode", 64'(an0), 64'(e[3:0]));
          check("dut0 seg", 64'(sg0), 64'(e[23:16]));
          check("dut0 lit cycles", 64'(len0), 64'(e[31:24]));
          check("dut0 slot gap", 64'(gap0), 64'(e[39:32]));
        end
      end
      if (!on0 && anode0 != 4'hF) begin
        on0 = 1'b1; an0 = anode0; sg0 = seg0; len0 = 1;
        gap0 = cyc0 - last0; last0 = cyc0;
      end
    end
  end
`endif

  // dut1: same episode monitor for the 5-digit, no-blank instance.
  always @(negedge clk) begin : mon1
    logic [39:0] e;
    if (!rst1_n) begin
      cyc1 = 0; last1 = 0; fsl1 = 0; on1 = 1'b0;
    end else begin
      cyc1++;
      if (fs1) begin
        if (fs1_q.size() > 0) check("dut1 frame_start interval", 64'(cyc1 - fsl1), 64'(fs1_q.pop_front()));
        fsl1 = cyc1;
      end
      if (on1 && anode1 == an1) begin
        len1++;
      end else if (on1) begin
        on1 = 1'b0;
        if (exp1_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL dut1 unexpected lit digit: anode %b seg %h, none expected", an1, sg1);
        end else begin
          e = exp1_q.pop_front();
          check("dut1 anode", 64'(an1), 64'(e[4:0]));
          check("dut1 seg", 64'(sg1), 64'(e[23:16]));
          check("dut1 lit cycles", 64'(len1), 64'(e[31:24]));
          check("dut1 slot gap", 64'(gap1), 64'(e[39:32]));
        end
      end
      if (!on1 && anode1 != 5'h1F) begin
        on1 = 1'b1; an1 = anode1; sg1 = seg1; len1 = 1;
        gap1 = cyc1 - last1; last1 = cyc1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_drain(input int which, input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (which == 0) done = (exp0_q.size() == 0) && !on0;
      else            done = (exp1_q.size() == 0) && !on1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL dut%0d drain timeout: expected episodes still queued after %0d cycles", which, budget);
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_anode0(input logic [3:0] pat, input int budget);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      hit = (anode0 == pat);
    end
    if (!hit) begin
      checks++; errors++;
      $display("FAIL dut0 wait anode %b: timeout after %0d cycles", pat, budget);
    end
  endtask

  task automatic reset_checks0(input string tag);
    check({tag, " anode"}, 64'(anode0), 64'h0F);
    check({tag, " seg"}, 64'(seg0), 64'hFF);
    check({tag, " digit_addr"}, 64'(addr0), 64'h0);
    check({tag, " frame_start"}, 64'(fs0), 64'h0);
  endtask

`ifdef SEG_DIM_EN
  task automatic wait_fs0(input int budget);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      hit = fs0;
    end
    if (!hit) begin
      checks++; errors++;
      $display("FAIL dut0 frame_start timeout after %0d cycles", budget);
    end
  endtask

  // Counts lit samples per digit over one full frame after a frame_start.
  task automatic count_frame(output int lit [4], output int any_lit);
    for (int d = 0; d < 4; d++) lit[d] = 0;
    any_lit = 0;
    for (int i = 0; i < ND0 * (SD0 + BC0 + 2); i++) begin
      @(negedge clk);
      if (anode0 != 4'hF) any_lit++;
      for (int d = 0; d < 4; d++) if (anode0 == ~(4'b0001 << d)) lit[d]++;
    end
  endtask
`endif

  // ---------------- stimulus ----------------
  initial begin
    rst0_n = 1'b0; rst1_n = 1'b0;
    raw0 = 1'b1; raw1 = 1'b1;
    mask0 = '0; mask1 = '0;
    for (int i = 0; i < 4; i++) mem0[i] = 8'(i);
    for (int i = 0; i < 5; i++) mem1[i] = 8'h20 + 8'(i);
`ifdef SEG_DIM_EN
    bright0 = 4'd4; bright1 = 4'd15;
`endif
    repeat (3) @(posedge clk);
    #1;
    reset_checks0("reset");
    check("dut1 reset anode", 64'(anode1), 64'h1F);

`ifdef SEG_DIM_EN
    begin
      int lit [4];
      int any_lit;
      rst0_n = 1'b1;
      wait_fs0(300);
      count_frame(lit, any_lit);
      // brightness 4 of 16 over 32 SHOW cycles -> 8 lit cycles per digit
      for (int d = 0; d < 4; d++) check($sformatf("dim4 digit%0d lit", d), 64'(lit[d]), 64'd8);
      @(posedge clk); #1;
      bright0 = 4'd0;
      wait_fs0(300);
      count_frame(lit, any_lit);
      check("dim0 lit cycles", 64'(any_lit), 64'd0);
    end
`else
    // Test 1: raw data i for digit i; first lit 3 samples after release.
    push0(4'hE, 8'h00, 3);
    push0(4'hD, 8'h01, 8);
    push0(4'hB, 8'h02, 8);
    push0(4'h7, 8'h03, 8);
    push0(4'hE, 8'h00, 8);
    push0(4'hD, 8'h01, 8);
    push0(4'hB, 8'h02, 8);
    push0(4'h7, 8'h03, 8);
    fs0_q.push_back(2);
    for (int i = 0; i < 5; i++) fs0_q.push_back(32);
    @(posedge clk); #1;
    rst0_n = 1'b1;
    wait_drain(0, 400);

    // Test 2: hex decode. 0F: F lights a,e,f,g -> 0001110, dp off -> 8E.
    // 05 -> 5 = 0010010, dp off -> 92. 18 -> 8 + dp -> 00. 1A -> A + dp -> 08.
    raw0 = 1'b0;
    mem0[0] = 8'h0F; mem0[1] = 8'h05; mem0[2] = 8'h18; mem0[3] = 8'h1A;
    push0(4'hE, 8'h8E, 8);
    push0(4'hD, 8'h92, 8);
    push0(4'hB, 8'h00, 8);
    push0(4'h7, 8'h08, 8);
    wait_drain(0, 200);

    // Test 3: digit 2 masked; its slot still takes time, so digit 3 is 16 later.
    mask0 = 4'b0100;
    for (int r = 0; r < 2; r++) begin
      push0(4'hE, 8'h8E, 8);
      push0(4'hD, 8'h92, 8);
      push0(4'h7, 8'h08, 16);
    end
    wait_drain(0, 300);
    mask0 = 4'b0000;

    // Test 5: reset in the middle of digit 2's SHOW.
    raw0 = 1'b1;
    for (int i = 0; i < 4; i++) mem0[i] = 8'(i);
    push0(4'hE, 8'h00, 8);
    push0(4'hD, 8'h01, 8);
    wait_drain(0, 200);
    wait_anode0(4'hB, 50);
    @(posedge clk); #1;
    rst0_n = 1'b0;
    #1;
    reset_checks0("mid-show reset");
    push0(4'hE, 8'h00, 3);
    push0(4'hD, 8'h01, 8);
    push0(4'hB, 8'h02, 8);
    push0(4'h7, 8'h03, 8);
    check("dut0 frame_start entries used before reset", 64'(fs0_q.size()), 64'd0);
    fs0_q.push_back(2);
    repeat (3) @(posedge clk);
    #1;
    rst0_n = 1'b1;
    wait_drain(0, 200);
    rst0_n = 1'b0;

    // Test 4: 5 digits, no blanking: slot 6, wrap 4 -> 0.
    for (int r = 0; r < 2; r++) begin
      push1(5'h1E, 8'h20, (r == 0) ? 3 : 6);
      push1(5'h1D, 8'h21, 6);
      push1(5'h1B, 8'h22, 6);
      push1(5'h17, 8'h23, 6);
      push1(5'h0F, 8'h24, 6);
    end
    fs1_q.push_back(2);
    fs1_q.push_back(30);
    @(posedge clk); #1;
    rst1_n = 1'b1;
    wait_drain(1, 300);
    rst1_n = 1'b0;

    check("dut0 leftover episodes", 64'(exp0_q.size()), 64'd0);
    check("dut0 leftover frame_start", 64'(fs0_q.size()), 64'd0);
    check("dut1 leftover frame_start", 64'(fs1_q.size()), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
